// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and PC constants for the fetch PC unit
package fetch_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next PC select: redirect beats pending target beats sequential step
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_STEP = DEFAULT_PC_STEP
) (
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    input  logic [31:0] pc,
    input  logic        advance,
    output logic [31:0] next_pc
);

    // advance=0 re-issues the current pc (used after a killed fetch drains)
    always_comb begin
        if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end else if (advance) begin
            next_pc = pc + PC_STEP;
        end else begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register, single-outstanding instruction fetch and decode handoff
// FETCH_ALIGN_CHECK_EN: misaligned redirect targets enter a sticky FAULT state and raise fetch_misalign
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    input  logic        instr_ready
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic         pend_valid_q, pend_valid_d;
    logic         kill_q, kill_d;
    logic         imem_req_q, imem_req_d;
    logic [31:0]  imem_addr_q, imem_addr_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic [31:0]  instr_pc4_q, instr_pc4_d;
    logic [31:0]  tgt;
    logic [31:0]  sel_pc;
    logic         sel_advance;
`ifdef FETCH_ALIGN_CHECK_EN
    logic         fetch_misalign_q, fetch_misalign_d;
`endif

    assign tgt         = redirect_target & ~32'd3;
    assign sel_advance = (state_q == HOLD);

    next_pc_sel #(
        .PC_STEP(PC_STEP)
    ) u_next_pc_sel (
        .redirect_valid (redirect_valid),
        .redirect_target(tgt),
        .pend_valid     (pend_valid_q),
        .pend_target    (pend_target_q),
        .pc             (pc_q),
        .advance        (sel_advance),
        .next_pc        (sel_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        kill_d        = kill_q;
        imem_req_d    = 1'b0;
        imem_addr_d   = imem_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_pc4_d   = instr_pc4_q;

        case (state_q)
            ISSUE: begin
                if (imem_req_q && imem_ready) begin
                    state_d = WAIT;
                end
                // An issued request cannot be retargeted, so park the target and kill its data
                if (redirect_valid) begin
                    if (imem_req_q) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = tgt;
                        kill_d        = 1'b1;
                    end else begin
                        pc_d = tgt;
                    end
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d         = sel_pc;
                    pend_valid_d = 1'b0;
                    kill_d       = !imem_rvalid;
                    if (imem_rvalid) begin
                        state_d = ISSUE;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d       = 1'b0;
                        pc_d         = sel_pc;
                        pend_valid_d = 1'b0;
                        state_d      = ISSUE;
                    end else begin
                        instr_valid_d = 1'b1;
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_pc4_d   = pc_q + PC_STEP;
                        state_d       = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid || instr_ready) begin
                    pc_d          = sel_pc;
                    pend_valid_d  = 1'b0;
                    instr_valid_d = 1'b0;
                    state_d       = ISSUE;
                end
            end
            default: begin
            end
        endcase

`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            state_d       = FAULT;
            pc_d          = pc_q;
            pend_valid_d  = 1'b0;
            kill_d        = 1'b0;
            instr_valid_d = 1'b0;
        end
`endif

        // Request/address follow the next state so a fresh ISSUE presents its request immediately
        if (state_d == ISSUE) begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_d;
        end else if (state_d == FAULT) begin
            imem_req_d  = imem_req_q && !imem_ready;
        end

`ifdef FETCH_ALIGN_CHECK_EN
        fetch_misalign_d = (state_d == FAULT);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ISSUE;
            pc_q          <= RESET_PC;
            pend_target_q <= RESET_PC;
            pend_valid_q  <= 1'b0;
            kill_q        <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'd0;
            instr_pc_q    <= RESET_PC;
            instr_pc4_q   <= RESET_PC + PC_STEP;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_misalign_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            kill_q        <= kill_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_pc4_q   <= instr_pc4_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_misalign_q <= fetch_misalign_d;
`endif
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_pc4   = instr_pc4_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_misalign = fetch_misalign_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed bench for fetch_pc_unit (both FETCH_ALIGN_CHECK_EN builds)
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_ready;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int total = 0;
    int bad   = 0;

    fetch_pc_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc4      (instr_pc4),
        .instr_ready    (instr_ready)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        instr_ready    = 1'b1;
    endtask

    // Accept the presented request, return data one cycle later; ends in HOLD
    task automatic serve(input logic [31:0] data);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        imem_ready      = 1'b1;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'd0;
        instr_ready     = 1'b1;

        // reset values
        do_reset();
        chk("rst_req", imem_req, 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_3000);
        chk("rst_ivalid", instr_valid, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'h0000_3000);
        chk("rst_ipc4", instr_pc4, 32'h0000_3004);

        // free run
        tick();
        chk("run_req0", imem_req, 32'd1);
        chk("run_addr0", imem_addr, 32'h0000_3000);
        serve(32'h1111_0001);
        chk("run_ivalid0", instr_valid, 32'd1);
        chk("run_instr0", instr, 32'h1111_0001);
        chk("run_ipc0", instr_pc, 32'h0000_3000);
        chk("run_ipc4_0", instr_pc4, 32'h0000_3004);
        tick();
        chk("run_addr1", imem_addr, 32'h0000_3004);
        chk("run_req1", imem_req, 32'd1);
        chk("run_ivalid1", instr_valid, 32'd0);
        serve(32'h1111_0002);
        chk("run_instr1", instr, 32'h1111_0002);
        tick();
        chk("run_addr2", imem_addr, 32'h0000_3008);

        // redirect in HOLD
        do_reset();
        tick();
        serve(32'h2222_0001);
        tick();
        instr_ready = 1'b0;
        serve(32'h2222_0002);
        chk("hold_ipc", instr_pc, 32'h0000_3004);
        tick();
        chk("hold_stay", instr_valid, 32'd1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_3100;
        instr_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("hold_rd_ivalid", instr_valid, 32'd0);
        chk("hold_rd_req", imem_req, 32'd1);
        chk("hold_rd_addr", imem_addr, 32'h0000_3100);
        serve(32'h2222_0003);
        chk("hold_rd_ipc", instr_pc, 32'h0000_3100);
        chk("hold_rd_ipc4", instr_pc4, 32'h0000_3104);

        // redirect in WAIT with same-cycle rvalid
        do_reset();
        tick();
        serve(32'h3333_0001);
        tick();
        serve(32'h3333_0002);
        tick();
        chk("wait_addr", imem_addr, 32'h0000_3008);
        tick();
        imem_rvalid     = 1'b1;
        imem_rdata      = 32'hDEAD_BEEF;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0040;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        chk("wait_ivalid", instr_valid, 32'd0);
        chk("wait_req", imem_req, 32'd1);
        chk("wait_addr2", imem_addr, 32'h0000_0040);
        serve(32'h3333_0003);
        chk("wait_instr", instr, 32'h3333_0003);
        chk("wait_ipc", instr_pc, 32'h0000_0040);

        // back-pressure with redirect in its second cycle
        do_reset();
        imem_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            redirect_valid  = (i == 1);
            redirect_target = 32'h0000_2000;
            tick();
            chk("bp_addr", imem_addr, 32'h0000_3000);
            chk("bp_req", imem_req, 32'd1);
        end
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_3000;
        tick();
        imem_rvalid = 1'b0;
        chk("bp_kill_ivalid", instr_valid, 32'd0);
        chk("bp_next_addr", imem_addr, 32'h0000_2000);
        chk("bp_next_req", imem_req, 32'd1);
        serve(32'h4444_0001);
        chk("bp_ipc", instr_pc, 32'h0000_2000);
        chk("bp_instr", instr, 32'h4444_0001);

        // wrap-around
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        serve(32'h5555_0001);
        chk("wrap_ipc4", instr_pc4, 32'h0000_0000);
        tick();
        chk("wrap_addr1", imem_addr, 32'h0000_0000);

        // misaligned redirect
        serve(32'h6666_0001);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_3102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_flag", fetch_misalign, 32'd1);
        chk("mis_req", imem_req, 32'd0);
        chk("mis_ivalid", instr_valid, 32'd0);
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = (i == 1);
            tick();
            chk("mis_sticky_req", imem_req, 32'd0);
            chk("mis_sticky_flag", fetch_misalign, 32'd1);
            chk("mis_sticky_ivalid", instr_valid, 32'd0);
        end
        imem_rvalid = 1'b0;
`else
        chk("mis_req", imem_req, 32'd1);
        chk("mis_addr", imem_addr, 32'h0000_3100);
`endif

        // reset overrides a simultaneous redirect
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_5000;
        reset           = 1'b0;
        tick();
        tick();
        do_reset();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst2_flag", fetch_misalign, 32'd0);
`endif
        tick();
        chk("rst2_addr", imem_addr, 32'h0000_3000);
        chk("rst2_req", imem_req, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
